// File: rtl/iter_alu_if.sv
// Request/response bundle between the EX-stage control FSM (master) and the
// iterative ALU (slave).
interface iter_alu_if #(
  parameter int WORD_SIZE = 16
);
  logic                 start;
  logic [3:0]           funcCode;
  logic [WORD_SIZE-1:0] op1;
  logic [WORD_SIZE-1:0] op2;
  logic                 ready;
  logic                 done;
  logic [WORD_SIZE-1:0] aResult;
  logic [WORD_SIZE-1:0] hResult;
  logic                 bResult;
  logic                 overflow;
  logic                 divZero;

  modport master (
    output start, funcCode, op1, op2,
    input  ready, done, aResult, hResult, bResult, overflow, divZero
  );

  modport slave (
    input  start, funcCode, op1, op2,
    output ready, done, aResult, hResult, bResult, overflow, divZero
  );
endinterface

// File: rtl/iter_alu.sv
// Multicycle ALU: single-cycle logic/arithmetic ops plus iterative unsigned
// multiply, restoring divide and variable left shift behind start/done.
// WORD_SIZE must be even and >= 4.
module iter_alu #(
  parameter int WORD_SIZE = 16
) (
  input  logic     clk,
  input  logic     reset,
  iter_alu_if.slave bus
);
  localparam int W       = WORD_SIZE;
  localparam int SHAMT_W = $clog2(WORD_SIZE);
  localparam int CNT_W   = SHAMT_W + 1;

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_AND  = 4'd2;
  localparam logic [3:0] F_ORR  = 4'd3;
  localparam logic [3:0] F_NOT  = 4'd4;
  localparam logic [3:0] F_TCP  = 4'd5;
  localparam logic [3:0] F_SHL  = 4'd6;
  localparam logic [3:0] F_SHR  = 4'd7;
  localparam logic [3:0] F_LHI  = 4'd8;
  localparam logic [3:0] F_MUL  = 4'd9;
  localparam logic [3:0] F_DIV  = 4'd10;
  localparam logic [3:0] F_SLLV = 4'd11;
  localparam logic [3:0] F_BNE  = 4'd12;
  localparam logic [3:0] F_BEQ  = 4'd13;
  localparam logic [3:0] F_BGZ  = 4'd14;
  localparam logic [3:0] F_BLZ  = 4'd15;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [3:0]     func_reg;
  logic [W-1:0]   a_reg;       // multiplicand for MUL
  logic [W-1:0]   b_reg;       // divisor for DIV
  logic [W-1:0]   hi_reg;      // partial product high / partial remainder
  logic [W-1:0]   lo_reg;      // multiplier-product low / dividend-quotient / shift value
  logic [CNT_W-1:0] cnt_reg;

  logic [W-1:0]   a_out_reg, h_out_reg;
  logic           b_out_reg, ovf_out_reg, dz_out_reg;

  logic           accept;
  logic [CNT_W-1:0] iter_cnt;
  logic [W-1:0]   fast_a, fast_h;
  logic           fast_b, fast_ovf, fast_dz;
  logic [W-1:0]   sum, diff;
  logic [W-1:0]   step_hi, step_lo;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;

  assign accept = (state_reg == IDLE) && bus.start;

  // Iteration count and zero-iteration results, straight from the bus inputs
  always_comb begin
    sum      = bus.op1 + bus.op2;
    diff     = bus.op1 - bus.op2;
    iter_cnt = '0;
    fast_a   = '0;
    fast_h   = '0;
    fast_b   = 1'b0;
    fast_ovf = 1'b0;
    fast_dz  = 1'b0;
    case (bus.funcCode)
      F_ADD: begin
        fast_a   = sum;
        fast_ovf = (bus.op1[W-1] == bus.op2[W-1]) && (sum[W-1] != bus.op1[W-1]);
      end
      F_SUB: begin
        fast_a   = diff;
        fast_ovf = (bus.op1[W-1] != bus.op2[W-1]) && (diff[W-1] != bus.op1[W-1]);
      end
      F_AND: fast_a = bus.op1 & bus.op2;
      F_ORR: fast_a = bus.op1 | bus.op2;
      F_NOT: fast_a = ~bus.op1;
      F_TCP: fast_a = '0 - bus.op1;
      F_SHL: fast_a = {bus.op1[W-2:0], 1'b0};
      F_SHR: fast_a = {bus.op1[W-1], bus.op1[W-1:1]};
      F_LHI: fast_a = bus.op2 << (W / 2);
      F_MUL: iter_cnt = CNT_W'(W);
      F_DIV: begin
        if (bus.op2 == '0) begin
          fast_a  = '1;
          fast_h  = bus.op1;
          fast_dz = 1'b1;
        end else begin
          iter_cnt = CNT_W'(W);
        end
      end
      F_SLLV: begin
        // Only reaches the outputs when the shift amount is zero
        fast_a   = bus.op1;
        iter_cnt = {1'b0, bus.op2[SHAMT_W-1:0]};
      end
      F_BNE: fast_b = (bus.op1 != bus.op2);
      F_BEQ: fast_b = (bus.op1 == bus.op2);
      F_BGZ: fast_b = !bus.op1[W-1] && (bus.op1 != '0);
      F_BLZ: fast_b = bus.op1[W-1];
      default: ;
    endcase
  end

  // One iteration of the captured multicycle op
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
    div_shift = {hi_reg, lo_reg[W-1]};
    step_hi   = hi_reg;
    step_lo   = lo_reg;
    case (func_reg)
      F_MUL: begin
        step_hi = mul_sum[W:1];
        step_lo = {mul_sum[0], lo_reg[W-1:1]};
      end
      F_DIV: begin
        // Remainder < divisor, so the W-bit modular difference is exact
        if (div_shift >= {1'b0, b_reg}) begin
          step_hi = div_shift[W-1:0] - b_reg;
          step_lo = {lo_reg[W-2:0], 1'b1};
        end else begin
          step_hi = div_shift[W-1:0];
          step_lo = {lo_reg[W-2:0], 1'b0};
        end
      end
      F_SLLV: step_lo = {lo_reg[W-2:0], 1'b0};
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_next = state_reg;
    bus.ready  = 1'b0;
    bus.done   = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_next = (iter_cnt == '0) ? DONE : RUN;
      end
      RUN:  if (cnt_reg == CNT_W'(1)) state_next = DONE;
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      func_reg    <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      cnt_reg     <= '0;
      a_out_reg   <= '0;
      h_out_reg   <= '0;
      b_out_reg   <= 1'b0;
      ovf_out_reg <= 1'b0;
      dz_out_reg  <= 1'b0;
    end else if (accept) begin
      func_reg <= bus.funcCode;
      a_reg    <= bus.op1;
      b_reg    <= bus.op2;
      hi_reg   <= '0;
      lo_reg   <= (bus.funcCode == F_MUL) ? bus.op2 : bus.op1;
      cnt_reg  <= iter_cnt;
      if (iter_cnt == '0) begin
        a_out_reg   <= fast_a;
        h_out_reg   <= fast_h;
        b_out_reg   <= fast_b;
        ovf_out_reg <= fast_ovf;
        dz_out_reg  <= fast_dz;
      end
    end else if (state_reg == RUN) begin
      hi_reg  <= step_hi;
      lo_reg  <= step_lo;
      cnt_reg <= cnt_reg - CNT_W'(1);
      if (cnt_reg == CNT_W'(1)) begin
        a_out_reg   <= step_lo;
        h_out_reg   <= (func_reg == F_SLLV) ? '0 : step_hi;
        b_out_reg   <= 1'b0;
        ovf_out_reg <= 1'b0;
        dz_out_reg  <= 1'b0;
      end
    end
  end

  assign bus.aResult  = a_out_reg;
  assign bus.hResult  = h_out_reg;
  assign bus.bResult  = b_out_reg;
  assign bus.overflow = ovf_out_reg;
  assign bus.divZero  = dz_out_reg;
endmodule

// File: tb/tb_iter_alu.sv
// Directed table-driven bench for iter_alu plus hand sequences for reset
// mid-iteration, ignored starts and back-to-back issue.
module tb_iter_alu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  iter_alu_if #(.WORD_SIZE(16)) bus ();
  iter_alu #(.WORD_SIZE(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [3:0]  f;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ea;
    logic [15:0] eh;
    logic        eb;
    logic        eo;
    logic        ez;
    int          lat;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op and wait (bounded) for done; lat = cycles from accept to done
  task automatic run_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                        output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.funcCode = f; bus.op1 = a; bus.op2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int dones;
    vecs[0]  = '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1};
    vecs[2]  = '{4'd9,  16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0, 1'b0, 1'b0, 17};
    vecs[3]  = '{4'd10, 16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 1'b0, 1'b0, 17};
    vecs[4]  = '{4'd10, 16'h0055, 16'h0000, 16'hFFFF, 16'h0055, 1'b0, 1'b0, 1'b1, 1};
    vecs[5]  = '{4'd11, 16'h0003, 16'h0004, 16'h0030, 16'h0000, 1'b0, 1'b0, 1'b0, 5};
    vecs[6]  = '{4'd11, 16'h0003, 16'h0010, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{4'd15, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
    vecs[8]  = '{4'd14, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'd13, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
    vecs[10] = '{4'd12, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{4'd8,  16'h0000, 16'h00AB, 16'hAB00, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{4'd2,  16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[13] = '{4'd3,  16'hF0F0, 16'h0F00, 16'hFFF0, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[14] = '{4'd4,  16'h00FF, 16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[15] = '{4'd5,  16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[16] = '{4'd6,  16'h8001, 16'h0000, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[17] = '{4'd7,  16'h8002, 16'h0000, 16'hC001, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[18] = '{4'd9,  16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0, 17};
    vecs[19] = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[20] = '{4'd14, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
    vecs[21] = '{4'd14, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[22] = '{4'd10, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 17};
    vecs[23] = '{4'd11, 16'h0001, 16'h000F, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 16};
    vecs[24] = '{4'd10, 16'h0005, 16'h0007, 16'h0000, 16'h0005, 1'b0, 1'b0, 1'b0, 17};
    vecs[25] = '{4'd1,  16'h7FFF, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1};

    bus.start = 1'b0; bus.funcCode = 4'd0; bus.op1 = '0; bus.op2 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_a", 32'(bus.aResult), 32'd0);
    check("rst_h", 32'(bus.hResult), 32'd0);
    check("rst_flags", {29'd0, bus.bResult, bus.overflow, bus.divZero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 26; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, lat);
      $display("vec %0d f=%0d op1=%h op2=%h -> a=%h h=%h b=%b ov=%b dz=%b lat=%0d",
               i, vecs[i].f, vecs[i].a, vecs[i].b, bus.aResult, bus.hResult,
               bus.bResult, bus.overflow, bus.divZero, lat);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_a", i), 32'(bus.aResult), 32'(vecs[i].ea));
      check($sformatf("v%0d_h", i), 32'(bus.hResult), 32'(vecs[i].eh));
      check($sformatf("v%0d_b", i), 32'(bus.bResult), 32'(vecs[i].eb));
      check($sformatf("v%0d_ov", i), 32'(bus.overflow), 32'(vecs[i].eo));
      check($sformatf("v%0d_dz", i), 32'(bus.divZero), 32'(vecs[i].ez));
      check($sformatf("v%0d_rdy_in_done", i), 32'(bus.ready), 32'd0);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), {30'd0, bus.done, bus.ready}, 32'd1);
    end

    // MUL with start held high (with other operands) during RUN: ignored
    @(negedge clk);
    bus.start = 1'b1; bus.funcCode = 4'd9; bus.op1 = 16'h1234; bus.op2 = 16'h0010;
    @(posedge clk); #1;
    bus.funcCode = 4'd0; bus.op1 = 16'h0001; bus.op2 = 16'h0001;
    lat = 1;
    while (!bus.done && lat < 100) begin
      if (lat == 6) bus.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    $display("mul_ignore_start: a=%h h=%h lat=%0d", bus.aResult, bus.hResult, lat);
    check("mulign_lat", 32'(lat), 32'd17);
    check("mulign_a", 32'(bus.aResult), 32'h2340);
    check("mulign_h", 32'(bus.hResult), 32'h0001);
    @(posedge clk); #1;

    // Reset in the 5th RUN cycle of a MUL
    @(negedge clk);
    bus.start = 1'b1; bus.funcCode = 4'd9; bus.op1 = 16'hFFFF; bus.op2 = 16'hFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    $display("reset_mid_mul: ready=%b done=%b a=%h h=%h", bus.ready, bus.done,
             bus.aResult, bus.hResult);
    check("rstmul_ready", 32'(bus.ready), 32'd1);
    check("rstmul_done", 32'(bus.done), 32'd0);
    check("rstmul_a", 32'(bus.aResult), 32'd0);
    check("rstmul_h", 32'(bus.hResult), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("rstmul_no_done", 32'(dones), 32'd0);
    run_op(4'd0, 16'h0003, 16'h0004, lat);
    $display("add_after_reset: a=%h lat=%0d", bus.aResult, lat);
    check("rstadd_lat", 32'(lat), 32'd1);
    check("rstadd_a", 32'(bus.aResult), 32'h0007);
    @(posedge clk); #1;

    // Back-to-back: second start accepted when ready returns, 2 cycles later
    @(negedge clk);
    bus.start = 1'b1; bus.funcCode = 4'd0; bus.op1 = 16'h0001; bus.op2 = 16'h0002;
    @(posedge clk); #1;
    check("b2b_done1", 32'(bus.done), 32'd1);
    check("b2b_a1", 32'(bus.aResult), 32'h0003);
    @(negedge clk);
    bus.op1 = 16'h0005; bus.op2 = 16'h0006;
    @(posedge clk); #1;
    check("b2b_idle", {30'd0, bus.done, bus.ready}, 32'd1);
    check("b2b_hold_a", 32'(bus.aResult), 32'h0003);
    @(posedge clk); #1;
    bus.start = 1'b0;
    $display("back_to_back: done=%b a=%h", bus.done, bus.aResult);
    check("b2b_done2", 32'(bus.done), 32'd1);
    check("b2b_a2", 32'(bus.aResult), 32'h000B);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
